// File: rtl/reg_demux_writer.sv
// reg_demux_writer
//   Write side of the 8-bit operand register bank. Decodes a 2-bit select and
//   updates one of four registers. It has two modes:
//     - load: a single-cycle write of wr_data.
//     - XOR-accumulate: a two-cycle read-modify-write (reg ^= wr_data).
//   The register outputs are direct flop outputs that feed the read-side 4:1 mux.
//
// Ports
//   clk       rising-edge system clock
//   rst_n     asynchronous active-low reset
//   clr       synchronous clear of all registers; wins over any request
//   wr_valid  write request present
//   wr_ready  request can be accepted this cycle (IDLE only)
//   wr_sel    destination select, same encoding as the read mux
//   wr_mode   0 = load, 1 = XOR-accumulate
//   wr_data   write operand
//   reg0..3   current register contents
//   wr_done   one-cycle pulse the cycle after a register is updated
module reg_demux_writer #(
  parameter int unsigned           WIDTH     = 8,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [1:0]       wr_sel,
  input  logic             wr_mode,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] reg0,
  output logic [WIDTH-1:0] reg1,
  output logic [WIDTH-1:0] reg2,
  output logic [WIDTH-1:0] reg3,
  output logic             wr_done
);

  typedef enum logic [0:0] {StIdle, StXorExec} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] regs_q [4];
  logic [1:0]       sel_q;
  logic [WIDTH-1:0] data_q;
  logic             done_q;
  logic [1:0]       wr_idx;

  // The read mux treats wr_sel[0] as the index MSB, so swap the bits.
  assign wr_idx   = {wr_sel[0], wr_sel[1]};
  assign wr_ready = (state_q == StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= RESET_VAL;
      state_q <= StIdle;
      sel_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else if (clr) begin
      // Discards a same-edge request and cancels a pending XOR.
      for (int i = 0; i < 4; i++) regs_q[i] <= RESET_VAL;
      state_q <= StIdle;
      sel_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (wr_valid) begin
            if (!wr_mode) begin
              regs_q[wr_idx] <= wr_data;
              done_q         <= 1'b1;
            end else begin
              sel_q   <= wr_idx;
              data_q  <= wr_data;
              state_q <= StXorExec;
            end
          end
        end
        StXorExec: begin
          // wr_valid is ignored here; wr_ready is low.
          regs_q[sel_q] <= regs_q[sel_q] ^ data_q;
          done_q        <= 1'b1;
          state_q       <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign reg0    = regs_q[0];
  assign reg1    = regs_q[1];
  assign reg2    = regs_q[2];
  assign reg3    = regs_q[3];
  assign wr_done = done_q;

endmodule

// File: tb/tb_reg_demux_writer.sv
module tb_reg_demux_writer;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_sel;
  logic       wr_mode;
  logic [7:0] wr_data;
  logic [7:0] reg0, reg1, reg2, reg3;
  logic       wr_done;

  int n_vec;
  int n_miscmp;

  // Expected bank snapshot {reg0, reg1, reg2, reg3} for each wr_done pulse.
  logic [31:0] exp_q [$];

  reg_demux_writer #(
    .WIDTH    (8),
    .RESET_VAL(8'h00)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_sel  (wr_sel),
    .wr_mode (wr_mode),
    .wr_data (wr_data),
    .reg0    (reg0),
    .reg1    (reg1),
    .reg2    (reg2),
    .reg3    (reg3),
    .wr_done (wr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bank(input logic [7:0] r0, input logic [7:0] r1,
                                       input logic [7:0] r2, input logic [7:0] r3);
    return {r0, r1, r2, r3};
  endfunction

  // Monitor: every wr_done pulse must match the next queued snapshot.
  initial begin
    forever begin
      @(negedge clk);
      if (wr_done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_wr_done", 32'd1, 32'd0);
        end else begin
          check("done_snapshot", {reg0, reg1, reg2, reg3}, exp_q.pop_front());
        end
      end
    end
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic m, input logic [7:0] d);
    wr_valid = v;
    wr_sel   = s;
    wr_mode  = m;
    wr_data  = d;
  endtask

  initial begin
    n_vec    = 0;
    n_miscmp = 0;
    rst_n    = 1'b0;
    clr      = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 8'h00);

    // Reset state.
    #2;
    check("rst_regs", {reg0, reg1, reg2, reg3}, 32'h0);
    check("rst_ready", {31'd0, wr_ready}, 32'd1);
    check("rst_done", {31'd0, wr_done}, 32'd0);
    // A request held during reset edges must not be taken.
    drive(1'b1, 2'b00, 1'b0, 8'hEE);
    edge1();
    check("no_accept_in_rst", {24'd0, reg0}, 32'h0);
    drive(1'b0, 2'b00, 1'b0, 8'h00);
    #2 rst_n = 1'b1;

    // Single load to reg1 (sel 10).
    edge1();
    drive(1'b1, 2'b10, 1'b0, 8'hA5);
    exp_q.push_back(bank(8'h00, 8'hA5, 8'h00, 8'h00));
    edge1();
    drive(1'b0, 2'b00, 1'b0, 8'h00);
    edge1();
    check("single_done_gone", {31'd0, wr_done}, 32'd0);

    // Back-to-back loads, sel 00/01/10/11.
    drive(1'b1, 2'b00, 1'b0, 8'h11);
    exp_q.push_back(bank(8'h11, 8'hA5, 8'h00, 8'h00));
    edge1();
    check("b2b_ready0", {31'd0, wr_ready}, 32'd1);
    drive(1'b1, 2'b01, 1'b0, 8'h22);
    exp_q.push_back(bank(8'h11, 8'hA5, 8'h22, 8'h00));
    edge1();
    check("b2b_ready1", {31'd0, wr_ready}, 32'd1);
    drive(1'b1, 2'b10, 1'b0, 8'h33);
    exp_q.push_back(bank(8'h11, 8'h33, 8'h22, 8'h00));
    edge1();
    check("b2b_ready2", {31'd0, wr_ready}, 32'd1);
    drive(1'b1, 2'b11, 1'b0, 8'h44);
    exp_q.push_back(bank(8'h11, 8'h33, 8'h22, 8'h44));
    edge1();
    check("b2b_ready3", {31'd0, wr_ready}, 32'd1);

    // reg3 = F0, then XOR 3C -> CC; valid stays high through XOR_EXEC.
    drive(1'b1, 2'b11, 1'b0, 8'hF0);
    exp_q.push_back(bank(8'h11, 8'h33, 8'h22, 8'hF0));
    edge1();
    drive(1'b1, 2'b11, 1'b1, 8'h3C);
    exp_q.push_back(bank(8'h11, 8'h33, 8'h22, 8'hCC));
    edge1();
    check("xor_ready_low", {31'd0, wr_ready}, 32'd0);
    check("xor_no_early_write", {24'd0, reg3}, 32'hF0);
    drive(1'b1, 2'b00, 1'b0, 8'hFF);  // must be ignored
    edge1();
    check("xor_ready_back", {31'd0, wr_ready}, 32'd1);
    check("xor_result", {reg0, reg1, reg2, reg3}, bank(8'h11, 8'h33, 8'h22, 8'hCC));
    drive(1'b0, 2'b00, 1'b0, 8'h00);
    edge1();
    check("xor_single_done", {31'd0, wr_done}, 32'd0);

    // XOR accepted, clr during XOR_EXEC cancels it.
    drive(1'b1, 2'b00, 1'b1, 8'h0F);
    edge1();
    drive(1'b0, 2'b00, 1'b0, 8'h00);
    clr = 1'b1;
    edge1();
    clr = 1'b0;
    check("clr_xor_regs", {reg0, reg1, reg2, reg3}, 32'h0);
    check("clr_xor_done", {31'd0, wr_done}, 32'd0);
    check("clr_xor_ready", {31'd0, wr_ready}, 32'd1);
    edge1();
    check("clr_xor_done2", {31'd0, wr_done}, 32'd0);

    // Load 55 to reg2, then load 77 to reg2 with clr on the same edge.
    drive(1'b1, 2'b01, 1'b0, 8'h55);
    exp_q.push_back(bank(8'h00, 8'h00, 8'h55, 8'h00));
    edge1();
    drive(1'b1, 2'b01, 1'b0, 8'h77);
    clr = 1'b1;
    edge1();
    clr = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 8'h00);
    check("clr_load_reg2", {24'd0, reg2}, 32'h00);
    check("clr_load_done", {31'd0, wr_done}, 32'd0);

    // Async reset mid-XOR.
    drive(1'b1, 2'b00, 1'b0, 8'h12);
    exp_q.push_back(bank(8'h12, 8'h00, 8'h00, 8'h00));
    edge1();
    drive(1'b1, 2'b01, 1'b1, 8'hAB);
    edge1();
    drive(1'b0, 2'b00, 1'b0, 8'h00);
    check("mid_xor_ready", {31'd0, wr_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_regs", {reg0, reg1, reg2, reg3}, 32'h0);
    check("async_rst_ready", {31'd0, wr_ready}, 32'd1);
    edge1();
    check("async_rst_done", {31'd0, wr_done}, 32'd0);
    #2 rst_n = 1'b1;
    edge1();
    drive(1'b1, 2'b11, 1'b0, 8'h5A);
    exp_q.push_back(bank(8'h00, 8'h00, 8'h00, 8'h5A));
    edge1();
    drive(1'b0, 2'b00, 1'b0, 8'h00);

    repeat (4) edge1();
    check("queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
